// File: rtl/capture_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_seq_ctrl
// Purpose  : Capture-run sequencer: burst write, idle gap, packet readout,
//            with MDIO debug reads sharing the capture-memory read port.
// Revision : 1.0 - initial release
// ============================================================================
module capture_seq_ctrl #(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk_200m,
    input  logic              rst_200m,
    input  logic              rf_capture_mode,
    input  logic              rf_capture_start,
    input  logic              rf_capture_again,
    input  logic              rf_96path_en,
    input  logic [1:0]        rf_pkt_data_length,
    input  logic [15:0]       rf_pkt_idle_length,
    input  logic              rf_mdio_read_pulse,
    input  logic [ADDR_W-1:0] rf_mdio_memory_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_src,
    output logic              grp_sel,
    output logic              pkt_valid,
    output logic              pkt_sop,
    output logic              pkt_eop,
    output logic              mdio_rd_done,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_capture = 3'd1;
    localparam logic [2:0] c_st_gap     = 3'd2;
    localparam logic [2:0] c_st_read    = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic [ADDR_W-1:0] c_last_1k  = ADDR_W'(1023);
    localparam logic [ADDR_W-1:0] c_last_4k  = ADDR_W'(4095);
    localparam logic [ADDR_W-1:0] c_last_16k = ADDR_W'(16383);
    localparam logic [ADDR_W-1:0] c_last_32k = ADDR_W'(32767);

    logic [2:0]        r_state;
    logic              r_start_q, r_again_q;
    logic [1:0]        r_len;
    logic [15:0]       r_idle;
    logic              r_grp_sel;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_ctr, r_rd_addr, r_mdio_addr;
    logic [15:0]       r_gap_cnt;
    logic              r_mdio_pend;
    logic              r_wr_en, r_rd_en, r_rd_src, r_busy, r_done;
    logic [RD_LAT-1:0] r_pv, r_ps, r_pe, r_md;

    logic              w_start_edge, w_again_edge, w_abort, w_latch;
    logic              w_mdio_take, w_stream_rd;
    logic [ADDR_W-1:0] w_last, w_wr_nxt, w_rd_nxt;
    logic [15:0]       w_gap_load, w_gap_nxt;
    logic [2:0]        w_state_nxt;

    assign w_start_edge = rf_capture_start & ~r_start_q;
    assign w_again_edge = rf_capture_again & ~r_again_q;
    assign w_abort      = ~rf_capture_start & (r_state != c_st_idle);
    assign w_mdio_take  = rf_mdio_read_pulse & ~r_mdio_pend;
    assign w_stream_rd  = r_rd_en & ~r_rd_src;
    assign w_gap_load   = (r_idle == 16'd0) ? 16'd1 : r_idle;

    always_comb begin
        case (r_len)
            2'b00:   w_last = c_last_1k;
            2'b01:   w_last = c_last_4k;
            2'b10:   w_last = c_last_16k;
            default: w_last = c_last_32k;
        endcase
    end

    // A pending MDIO read owns the current read slot, so the stream counter holds.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_addr;
        w_rd_nxt    = r_rd_ctr;
        w_gap_nxt   = r_gap_cnt;
        w_latch     = 1'b0;
        if (w_abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start_edge) begin
                        w_latch     = 1'b1;
                        w_state_nxt = c_st_capture;
                        w_wr_nxt    = '0;
                    end
                end
                c_st_capture: begin
                    if (r_wr_addr == w_last) begin
                        w_state_nxt = c_st_gap;
                        w_gap_nxt   = w_gap_load;
                        w_rd_nxt    = '0;
                    end else begin
                        w_wr_nxt = r_wr_addr + 1'b1;
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt <= 16'd1) w_state_nxt = c_st_read;
                    else                    w_gap_nxt   = r_gap_cnt - 16'd1;
                end
                c_st_read: begin
                    if (!r_mdio_pend) begin
                        if (r_rd_ctr == w_last) begin
                            if (rf_capture_mode) begin
                                w_state_nxt = c_st_capture;
                                w_wr_nxt    = '0;
                            end else begin
                                w_state_nxt = c_st_done;
                            end
                        end else begin
                            w_rd_nxt = r_rd_ctr + 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    if (w_start_edge || w_again_edge) begin
                        w_latch     = 1'b1;
                        w_state_nxt = c_st_capture;
                        w_wr_nxt    = '0;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            r_state     <= c_st_idle;
            r_start_q   <= 1'b1;
            r_again_q   <= 1'b1;
            r_len       <= '0;
            r_idle      <= '0;
            r_grp_sel   <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_ctr    <= '0;
            r_rd_addr   <= '0;
            r_mdio_addr <= '0;
            r_gap_cnt   <= '0;
            r_mdio_pend <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_src    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pv        <= '0;
            r_ps        <= '0;
            r_pe        <= '0;
            r_md        <= '0;
        end else begin
            r_start_q <= rf_capture_start;
            r_again_q <= rf_capture_again;
            r_state   <= w_state_nxt;
            r_wr_addr <= w_wr_nxt;
            r_rd_ctr  <= w_rd_nxt;
            r_gap_cnt <= w_gap_nxt;
            if (w_latch) begin
                r_len     <= rf_pkt_data_length;
                r_idle    <= rf_pkt_idle_length;
                r_grp_sel <= rf_96path_en;
            end
            r_mdio_pend <= w_mdio_take;
            if (w_mdio_take) r_mdio_addr <= rf_mdio_memory_addr;

            // Outputs are registered from next-state values so they line up with r_state.
            r_wr_en   <= (w_state_nxt == c_st_capture);
            r_rd_en   <= w_mdio_take | (w_state_nxt == c_st_read);
            r_rd_src  <= w_mdio_take;
            r_rd_addr <= w_mdio_take ? rf_mdio_memory_addr : w_rd_nxt;
            r_busy    <= (w_state_nxt == c_st_capture) || (w_state_nxt == c_st_gap) ||
                         (w_state_nxt == c_st_read);
            r_done    <= (w_state_nxt == c_st_done);

            for (int i = 1; i < RD_LAT; i++) r_md[i] <= r_md[i-1];
            r_md[0] <= r_rd_en & r_rd_src;
            if (w_abort) begin
                r_pv <= '0;
                r_ps <= '0;
                r_pe <= '0;
            end else begin
                for (int i = 1; i < RD_LAT; i++) begin
                    r_pv[i] <= r_pv[i-1];
                    r_ps[i] <= r_ps[i-1];
                    r_pe[i] <= r_pe[i-1];
                end
                r_pv[0] <= w_stream_rd;
                r_ps[0] <= w_stream_rd & (r_rd_addr == '0);
                r_pe[0] <= w_stream_rd & (r_rd_addr == w_last);
            end
        end
    end

    assign mem_wr_en    = r_wr_en;
    assign mem_wr_addr  = r_wr_addr;
    assign mem_rd_en    = r_rd_en;
    assign mem_rd_addr  = r_rd_addr;
    assign mem_rd_src   = r_rd_src;
    assign grp_sel      = r_grp_sel;
    assign pkt_valid    = r_pv[RD_LAT-1];
    assign pkt_sop      = r_ps[RD_LAT-1];
    assign pkt_eop      = r_pe[RD_LAT-1];
    assign mdio_rd_done = r_md[RD_LAT-1];
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_capture_seq_ctrl
// Purpose  : Directed self-checking bench for capture_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_seq_ctrl;

    localparam int ADDR_W = 15;
    localparam int RD_LAT = 1;

    logic              clk_200m = 1'b0;
    logic              rst_200m;
    logic              rf_capture_mode, rf_capture_start, rf_capture_again, rf_96path_en;
    logic [1:0]        rf_pkt_data_length;
    logic [15:0]       rf_pkt_idle_length;
    logic              rf_mdio_read_pulse;
    logic [ADDR_W-1:0] rf_mdio_memory_addr;
    logic              mem_wr_en, mem_rd_en, mem_rd_src, grp_sel;
    logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
    logic              pkt_valid, pkt_sop, pkt_eop, mdio_rd_done, busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #2.5 clk_200m = ~clk_200m;

    capture_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
        .clk_200m            (clk_200m),
        .rst_200m            (rst_200m),
        .rf_capture_mode     (rf_capture_mode),
        .rf_capture_start    (rf_capture_start),
        .rf_capture_again    (rf_capture_again),
        .rf_96path_en        (rf_96path_en),
        .rf_pkt_data_length  (rf_pkt_data_length),
        .rf_pkt_idle_length  (rf_pkt_idle_length),
        .rf_mdio_read_pulse  (rf_mdio_read_pulse),
        .rf_mdio_memory_addr (rf_mdio_memory_addr),
        .mem_wr_en           (mem_wr_en),
        .mem_wr_addr         (mem_wr_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_src          (mem_rd_src),
        .grp_sel             (grp_sel),
        .pkt_valid           (pkt_valid),
        .pkt_sop             (pkt_sop),
        .pkt_eop             (pkt_eop),
        .mdio_rd_done        (mdio_rd_done),
        .busy                (busy),
        .done                (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200m);
        #1;
    endtask

    // Observes one run from its first CAPTURE cycle up to DONE; optionally fires
    // one MDIO pulse in the cycle that streams address mdio_at-1.
    task automatic run_check(input string nm, input int depth, input int gap_exp,
                             input int mdio_at, input logic [ADDR_W-1:0] maddr,
                             input int busy_exp);
        int n_wr = 0, bad_wr = 0, n_gap = 0, n_rd = 0, bad_rd = 0;
        int n_pv = 0, bad_flag = 0, n_busy = 0, n_iss = 0, bad_iss = 0, n_mdone = 0;
        int iss_cyc = -1, mdone_cyc = -100, resume_addr = -1;
        bit pulsed = 1'b0, saw_done = 1'b0, after_iss = 1'b0;
        for (int cyc = 0; cyc < 2*depth + gap_exp + 64; cyc++) begin
            tick();
            rf_capture_again = 1'b0;
            if (pulsed) rf_mdio_read_pulse = 1'b0;
            if (busy) n_busy++;
            if (mem_wr_en) begin
                if (mem_wr_addr != ADDR_W'(n_wr)) bad_wr++;
                n_wr++;
            end
            if (busy && !mem_wr_en && !mem_rd_en) n_gap++;
            if (mem_rd_en && mem_rd_src) begin
                n_iss++;
                iss_cyc = cyc;
                if (mem_rd_addr != maddr) bad_iss++;
                after_iss = 1'b1;
            end else if (mem_rd_en) begin
                if (after_iss) begin
                    resume_addr = int'(mem_rd_addr);
                    after_iss   = 1'b0;
                end
                if (mem_rd_addr != ADDR_W'(n_rd)) bad_rd++;
                n_rd++;
                if (mdio_at > 0 && !pulsed && int'(mem_rd_addr) == mdio_at - 1) begin
                    rf_mdio_read_pulse = 1'b1;
                    pulsed = 1'b1;
                end
            end
            if (mdio_rd_done) begin
                n_mdone++;
                mdone_cyc = cyc;
            end
            if (pkt_valid) begin
                if (pkt_sop != (n_pv == 0) || pkt_eop != (n_pv == depth - 1)) bad_flag++;
                n_pv++;
            end else if (pkt_sop || pkt_eop) begin
                bad_flag++;
            end
            if (done) begin
                saw_done = 1'b1;
                break;
            end
        end
        chk({nm, "_wr_cnt"},   n_wr,     depth);
        chk({nm, "_wr_seq"},   bad_wr,   0);
        chk({nm, "_gap"},      n_gap,    gap_exp);
        chk({nm, "_rd_cnt"},   n_rd,     depth);
        chk({nm, "_rd_seq"},   bad_rd,   0);
        chk({nm, "_pv_cnt"},   n_pv,     depth);
        chk({nm, "_sop_eop"},  bad_flag, 0);
        chk({nm, "_busy_cyc"}, n_busy,   busy_exp);
        chk({nm, "_done"},     saw_done, 1);
        if (mdio_at > 0) begin
            chk({nm, "_mdio_iss"},    n_iss,               1);
            chk({nm, "_mdio_addr"},   bad_iss,             0);
            chk({nm, "_resume"},      resume_addr,         mdio_at);
            chk({nm, "_mdio_done"},   n_mdone,             1);
            chk({nm, "_mdio_lat"},    mdone_cyc - iss_cyc, RD_LAT);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_200m = 1'b1;
        rf_capture_mode = 1'b0;
        rf_capture_start = 1'b1;
        rf_capture_again = 1'b0;
        rf_96path_en = 1'b0;
        rf_pkt_data_length = 2'b00;
        rf_pkt_idle_length = 16'd4;
        rf_mdio_read_pulse = 1'b0;
        rf_mdio_memory_addr = '0;

        // Reset with start held high: everything idle, and no run afterwards
        repeat (3) tick();
        chk("rst_outs", {22'd0, mem_wr_en, mem_rd_en, mem_rd_src, grp_sel, pkt_valid,
                         pkt_sop, pkt_eop, mdio_rd_done, busy, done}, 32'd0);
        chk("rst_addrs", {2'd0, mem_wr_addr, mem_rd_addr}, 32'd0);
        rst_200m = 1'b0;
        repeat (4) tick();
        chk("rst_no_run", {30'd0, busy, mem_wr_en}, 32'd0);

        // 1024-sample run, idle 4, single shot, group select 1
        rf_capture_start = 1'b0;
        tick();
        rf_96path_en = 1'b1;
        rf_capture_start = 1'b1;
        run_check("run1k", 1024, 4, 0, '0, 2052);
        rf_96path_en = 1'b0;
        tick();
        chk("grp_latched", grp_sel, 1);
        chk("done_hold", {30'd0, done, busy}, 32'd2);

        // MDIO read interleaved into the stream at address 100
        rf_capture_start = 1'b0;
        tick();
        chk("abort_done", {30'd0, done, busy}, 32'd0);
        rf_pkt_idle_length = 16'd2;
        rf_mdio_memory_addr = ADDR_W'(16'h155);
        rf_capture_start = 1'b1;
        run_check("mdio", 1024, 2, 100, ADDR_W'(16'h155), 2051);

        // Continuous mode: CAPTURE follows the eop read directly
        rf_capture_start = 1'b0;
        tick();
        rf_capture_mode = 1'b1;
        rf_pkt_idle_length = 16'd0;
        rf_capture_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (mem_rd_en && !mem_rd_src && mem_rd_addr == ADDR_W'(1023)) found = 1'b1;
        end
        chk("mode1_last_rd", found, 1);
        tick();
        chk("mode1_recap", {16'd0, mem_wr_en, mem_wr_addr}, {16'd0, 1'b1, 15'd0});
        chk("mode1_eop", {30'd0, pkt_eop, busy}, 32'd3);

        // Abort mid-capture at address 500, then restart from 0
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (mem_wr_en && mem_wr_addr == ADDR_W'(500)) found = 1'b1;
            else tick();
        end
        chk("abort_at500", found, 1);
        rf_capture_start = 1'b0;
        tick();
        chk("abort_idle", {29'd0, mem_wr_en, busy, pkt_valid}, 32'd0);
        rf_capture_start = 1'b1;
        tick();
        chk("restart", {16'd0, mem_wr_en, mem_wr_addr}, {16'd0, 1'b1, 15'd0});
        rf_capture_start = 1'b0;
        tick();
        rf_capture_mode = 1'b0;

        // Idle 0 gives a 1-cycle gap; again edge re-runs with a re-latched 4096 depth
        rf_capture_start = 1'b1;
        run_check("idle0", 1024, 1, 0, '0, 2049);
        rf_pkt_data_length = 2'b01;
        rf_capture_again = 1'b1;
        run_check("again4k", 4096, 1, 0, '0, 8193);

        // Back-to-back MDIO pulses in IDLE: the second, arriving while pending, is dropped
        rf_capture_start = 1'b0;
        tick();
        rf_mdio_memory_addr = ADDR_W'(16'h0AA);
        rf_mdio_read_pulse = 1'b1;
        tick();
        rf_mdio_memory_addr = ADDR_W'(16'h0BB);
        chk("mdio_idle_iss", {15'd0, mem_rd_en, mem_rd_src, mem_rd_addr},
            {15'd0, 1'b1, 1'b1, 15'h0AA});
        tick();
        rf_mdio_read_pulse = 1'b0;
        chk("mdio_ignored", {30'd0, mem_rd_en, mdio_rd_done}, 32'd1);
        tick();
        chk("mdio_quiet", {30'd0, mem_rd_en, mdio_rd_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
